// File: rtl/result_denormalizer.sv
// Restores a truncated product to full scale by left-shifting it once per cycle,
// by the total number of low bits that were dropped from both operands.
module result_denormalizer #(
    parameter int n_effective = 8,
    parameter int n_input     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2*n_effective-1:0] pin,
    input  logic [3:0]             sh1,
    input  logic [3:0]             sh2,
    output logic                   busy,
    output logic                   done,
    output logic [2*n_input-1:0]   pout
);

    localparam int PW    = 2 * n_effective;
    localparam int RW    = 2 * n_input;
    localparam int MAXSH = n_input - n_effective;
    // Sized so that the sum of both clamped counts can never wrap.
    localparam int CW    = $clog2(2 * MAXSH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [RW-1:0]   r_res;
    logic [RW-1:0]   w_res_nxt;
    logic [CW-1:0]   w_eff1;
    logic [CW-1:0]   w_eff2;

    function automatic logic [CW-1:0] clamp_sh(input logic [3:0] sh);
        if (int'(sh) > MAXSH) begin
            return CW'(MAXSH);
        end else begin
            return CW'(sh);
        end
    endfunction

    assign w_eff1 = clamp_sh(sh1);
    assign w_eff2 = clamp_sh(sh2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_res   <= w_res_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_res_nxt   = r_res;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_res_nxt   = {{(RW-PW){1'b0}}, pin};
                    w_cnt_nxt   = w_eff1 + w_eff2;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt != '0) begin
                    w_res_nxt = {r_res[RW-2:0], 1'b0};
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status comes straight from the state register so start never reaches it combinationally.
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign pout = r_res;

endmodule
